// File: rtl/stack_op_sequencer.sv
// Stack traffic sequencer: PUSH/POP/CALL in one step, RET/INT/RTI
// as short stalled sequences returning PC redirect and flag data.
module stack_op_sequencer #(
  parameter logic [31:0] INT_VECTOR = 32'h0000_0000,
  parameter int          FLAGS_W    = 4
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_op_valid,
  input  logic [2:0]         i_op,
  input  logic [FLAGS_W-1:0] i_flags,
  input  logic [31:0]        i_mem_data,
  output logic               o_isStack,
  output logic               o_isPushPc,
  output logic               o_isPushFlags,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_en32,
  output logic [2:0]         o_sp_select,
  output logic               o_is_prev_sp,
  output logic               o_stall,
  output logic               o_busy,
  output logic               o_pc_redirect_valid,
  output logic [31:0]        o_pc_redirect,
  output logic               o_flags_restore_valid,
  output logic [FLAGS_W-1:0] o_flags_restore
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RET_WAIT,
    S_INT_FLAGS,
    S_RTI_PC,
    S_RTI_WAIT
  } state_t;

  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_INT  = 3'd5;
  localparam logic [2:0] OP_RTI  = 3'd6;

  localparam logic [2:0] SP_HOLD = 3'd0;
  localparam logic [2:0] SP_INC1 = 3'd1;
  localparam logic [2:0] SP_INC2 = 3'd2;
  localparam logic [2:0] SP_DEC1 = 3'd3;
  localparam logic [2:0] SP_DEC2 = 3'd4;

  state_t state, state_nx;

  // Flags travel to memory through the memory stage's own mux;
  // this block only selects them via o_isPushFlags.
  logic unused_flags;
  assign unused_flags = ^i_flags;

  // State register
  always_ff @(posedge clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next state and stack controls; every access here is SP-addressed
  always_comb begin
    state_nx      = state;
    o_isStack     = 1'b0;
    o_isPushPc    = 1'b0;
    o_isPushFlags = 1'b0;
    o_memRead     = 1'b0;
    o_memWrite    = 1'b0;
    o_en32        = 1'b0;
    o_sp_select   = SP_HOLD;
    o_is_prev_sp  = 1'b0;
    o_stall       = 1'b0;
    o_busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (i_op_valid && !i_reset) begin
          case (i_op)
            OP_PUSH: begin
              o_isStack   = 1'b1;
              o_memWrite  = 1'b1;
              o_sp_select = SP_DEC1;
            end
            OP_POP: begin
              o_isStack    = 1'b1;
              o_memRead    = 1'b1;
              o_sp_select  = SP_INC1;
              o_is_prev_sp = 1'b1;
            end
            OP_CALL: begin
              o_isStack   = 1'b1;
              o_memWrite  = 1'b1;
              o_isPushPc  = 1'b1;
              o_en32      = 1'b1;
              o_sp_select = SP_DEC2;
            end
            OP_RET: begin
              o_isStack    = 1'b1;
              o_memRead    = 1'b1;
              o_en32       = 1'b1;
              o_sp_select  = SP_INC2;
              o_is_prev_sp = 1'b1;
              o_stall      = 1'b1;
              state_nx     = S_RET_WAIT;
            end
            OP_INT: begin
              o_isStack   = 1'b1;
              o_isPushPc  = 1'b1;
              o_en32      = 1'b1;
              o_memWrite  = 1'b1;
              o_sp_select = SP_DEC2;
              o_stall     = 1'b1;
              state_nx    = S_INT_FLAGS;
            end
            OP_RTI: begin
              o_isStack    = 1'b1;
              o_memRead    = 1'b1;
              o_sp_select  = SP_INC1;
              o_is_prev_sp = 1'b1;
              o_stall      = 1'b1;
              state_nx     = S_RTI_PC;
            end
            default: ;
          endcase
        end
      end
      S_RET_WAIT, S_RTI_WAIT: begin
        o_stall  = 1'b1;
        state_nx = S_IDLE;
      end
      S_INT_FLAGS: begin
        o_isStack     = 1'b1;
        o_isPushFlags = 1'b1;
        o_memWrite    = 1'b1;
        o_sp_select   = SP_DEC1;
        o_stall       = 1'b1;
        state_nx      = S_IDLE;
      end
      S_RTI_PC: begin
        o_isStack    = 1'b1;
        o_memRead    = 1'b1;
        o_en32       = 1'b1;
        o_sp_select  = SP_INC2;
        o_is_prev_sp = 1'b1;
        o_stall      = 1'b1;
        state_nx     = S_RTI_WAIT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Redirect and flag-restore results, pulsed one cycle after capture
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_pc_redirect_valid   <= 1'b0;
      o_pc_redirect         <= '0;
      o_flags_restore_valid <= 1'b0;
      o_flags_restore       <= '0;
    end else begin
      o_pc_redirect_valid   <= 1'b0;
      o_flags_restore_valid <= 1'b0;
      case (state)
        S_RET_WAIT, S_RTI_WAIT: begin
          o_pc_redirect       <= i_mem_data;
          o_pc_redirect_valid <= 1'b1;
        end
        S_INT_FLAGS: begin
          o_pc_redirect       <= INT_VECTOR;
          o_pc_redirect_valid <= 1'b1;
        end
        S_RTI_PC: begin
          o_flags_restore       <= i_mem_data[FLAGS_W-1:0];
          o_flags_restore_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
